// File: rtl/f8_ctrl.sv
// rtl/f8_ctrl.sv - sequencing controller for the JH-style F8 permutation core
//
// Accepts 512-bit message blocks, XORs each into the top half of the chaining
// value before F8 and into the bottom half after it, and counts a fixed number
// of cycles to know when the F8 result is valid. Presents H[DIGEST_BITS-1:0]
// once the block flagged as last has been absorbed.
//
// Build option: F8CTRL_INIT_EN - when defined, INIT runs F8 once on the IV to
// produce the standard H0; when undefined, H starts at the raw IV.
//
// Ports:
//   clk, rst                  clock shared with F8; synchronous active-high reset
//   msg_valid/msg_ready       message block handshake
//   msg_data[511:0], msg_last block (bit 511 first) and final-block qualifier
//   f8_state_in[1023:0]       registered drive to F8 state_in
//   f8_state_out[1023:0]      F8 result
//   digest_valid/digest_ready digest handshake
//   digest_data               H[DIGEST_BITS-1:0] after the final block
//   busy                      low only while waiting for a message block
module f8_ctrl #(
  parameter int F8_LATENCY  = 42,
  parameter int DIGEST_BITS = 256
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   msg_valid,
  output logic                   msg_ready,
  input  logic [511:0]           msg_data,
  input  logic                   msg_last,
  output logic [1023:0]          f8_state_in,
  input  logic [1023:0]          f8_state_out,
  output logic                   digest_valid,
  input  logic                   digest_ready,
  output logic [DIGEST_BITS-1:0] digest_data,
  output logic                   busy
);

  localparam logic [1023:0] IV       = {16'(DIGEST_BITS), 1008'b0};
  localparam logic [7:0]    CNT_LAST = 8'(F8_LATENCY - 1);

  typedef enum logic [2:0] {
    S_INIT,
`ifdef F8CTRL_INIT_EN
    S_INIT_RUN,
`endif
    S_WAIT_MSG,
    S_RUN,
    S_OUT
  } state_t;

  state_t         state, state_d;
  logic [1023:0]  h_reg, h_d;
  logic [7:0]     cnt, cnt_d;
  logic [1023:0]  f8_in_d;
  logic [511:0]   msg_q, msg_d;
  logic           last_q, last_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_INIT;
      h_reg       <= IV;
      cnt         <= '0;
      f8_state_in <= '0;
      msg_q       <= '0;
      last_q      <= 1'b0;
    end else begin
      state       <= state_d;
      h_reg       <= h_d;
      cnt         <= cnt_d;
      f8_state_in <= f8_in_d;
      msg_q       <= msg_d;
      last_q      <= last_d;
    end
  end

  always_comb begin
    state_d      = state;
    h_d          = h_reg;
    cnt_d        = cnt;
    f8_in_d      = f8_state_in;
    msg_d        = msg_q;
    last_d       = last_q;
    msg_ready    = 1'b0;
    digest_valid = 1'b0;
    digest_data  = '0;
    busy         = 1'b1;

    case (state)
      S_INIT: begin
`ifdef F8CTRL_INIT_EN
        // Permute the IV once; the result is the standard H0.
        f8_in_d = IV;
        cnt_d   = '0;
        state_d = S_INIT_RUN;
`else
        h_d     = IV;
        state_d = S_WAIT_MSG;
`endif
      end

`ifdef F8CTRL_INIT_EN
      S_INIT_RUN: begin
        if (cnt == CNT_LAST) begin
          h_d     = f8_state_out;
          state_d = S_WAIT_MSG;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end
`endif

      S_WAIT_MSG: begin
        msg_ready = 1'b1;
        busy      = 1'b0;
        if (msg_valid) begin
          f8_in_d = h_reg ^ {msg_data, 512'b0};
          msg_d   = msg_data;
          last_d  = msg_last;
          cnt_d   = '0;
          state_d = S_RUN;
        end
      end

      S_RUN: begin
        // f8_state_in is held for the whole run so an iterative F8 also works.
        if (cnt == CNT_LAST) begin
          h_d     = f8_state_out ^ {512'b0, msg_q};
          state_d = last_q ? S_OUT : S_WAIT_MSG;
        end else begin
          cnt_d = cnt + 8'd1;
        end
      end

      S_OUT: begin
        digest_valid = 1'b1;
        digest_data  = h_reg[DIGEST_BITS-1:0];
        if (digest_ready) begin
          h_d     = IV;
          state_d = S_INIT;
        end
      end

      default: state_d = S_INIT;
    endcase
  end

endmodule

// File: tb/tb_f8_ctrl.sv
// tb/tb_f8_ctrl.sv - self-checking bench for f8_ctrl with an inverting F8 stub
module tb_f8_ctrl;

  localparam int L  = 4;
  localparam int DB = 256;
  localparam logic [1023:0] IV = {16'h0100, 1008'b0};

  localparam int P_INIT = 0;
  localparam int P_WAIT = 1;
  localparam int P_RUN  = 2;
  localparam int P_OUT  = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           msg_valid = 1'b0;
  logic           msg_ready;
  logic [511:0]   msg_data = '0;
  logic           msg_last = 1'b0;
  logic [1023:0]  f8_state_in;
  logic [1023:0]  f8_state_out;
  logic           digest_valid;
  logic           digest_ready = 1'b0;
  logic [DB-1:0]  digest_data;
  logic           busy;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b0;

  f8_ctrl #(.F8_LATENCY(L), .DIGEST_BITS(DB)) dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready),
    .msg_data(msg_data), .msg_last(msg_last),
    .f8_state_in(f8_state_in), .f8_state_out(f8_state_out),
    .digest_valid(digest_valid), .digest_ready(digest_ready),
    .digest_data(digest_data), .busy(busy)
  );

  always #5 clk = ~clk;

  // F8 stub: the value driven at an edge is seen inverted at the L-th edge after.
  logic [1023:0] pipe [L-1];
  always @(posedge clk) begin
    pipe[0] <= f8_state_in;
    for (int i = 1; i < L - 1; i++) pipe[i] <= pipe[i-1];
  end
  assign f8_state_out = ~pipe[L-2];

  // Transaction-level model: F8 is ideally ~x; a block's result lands L cycles
  // after the cycle it was accepted.
  int            cyc = 0;
  int            m_phase = P_INIT;
  int            ready_at = 0;
  logic [1023:0] mh = IV;
  logic [1023:0] m_fin = '0;
  logic [511:0]  m_msg = '0;
  bit            m_last = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_phase = P_INIT;
      mh      = IV;
      m_fin   = '0;
    end else begin
      case (m_phase)
        P_INIT: begin
          mh      = IV;
          m_phase = P_WAIT;
        end
        P_WAIT: if (msg_valid) begin
          m_fin    = mh ^ {msg_data, 512'b0};
          m_msg    = msg_data;
          m_last   = msg_last;
          ready_at = cyc + L;
          m_phase  = P_RUN;
        end
        P_RUN: if (cyc == ready_at) begin
          mh      = ~m_fin ^ {512'b0, m_msg};
          m_phase = m_last ? P_OUT : P_WAIT;
        end
        default: if (digest_ready) begin
          mh      = IV;
          m_phase = P_INIT;
        end
      endcase
    end
  end

  task automatic chk(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got hi=%h lo=%h want hi=%h lo=%h", name, $time,
               act[1023:960], act[63:0], exp[1023:960], exp[63:0]);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("m_msg_ready",    1024'(msg_ready),    1024'(m_phase == P_WAIT));
      chk("m_busy",         1024'(busy),         1024'(m_phase != P_WAIT));
      chk("m_digest_valid", 1024'(digest_valid), 1024'(m_phase == P_OUT));
      chk("m_digest_data",  1024'(digest_data),
          (m_phase == P_OUT) ? 1024'(mh[DB-1:0]) : 1024'(0));
      chk("m_f8_state_in",  f8_state_in, m_fin);
      chk("m_h",            dut.h_reg,   mh);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  logic [1023:0] h1;
  logic [255:0]  ones;

  initial begin
    h1   = {~(IV[1023:512] ^ {511'b0, 1'b1}), {511{1'b1}}, 1'b0};
    ones = '1;

    // Reset: two cycles high.
    rst = 1'b1;
    tick();
    chk_on = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_msg_ready", 1024'(msg_ready), 1024'(0));
    chk("rst_busy",      1024'(busy),      1024'(1));
    chk("rst_dvalid",    1024'(digest_valid), 1024'(0));
    chk("rst_f8_in",     f8_state_in, 1024'(0));
    chk("rst_ddata",     1024'(digest_data), 1024'(0));
    tick();
    chk("init_msg_ready", 1024'(msg_ready), 1024'(1));
    chk("init_busy",      1024'(busy),      1024'(0));
    chk("init_h",         dut.h_reg, IV);

    // Single zero block, last.
    msg_valid = 1'b1; msg_data = '0; msg_last = 1'b1;
    tick();
    msg_valid = 1'b0;
    chk("blk_f8_in", f8_state_in, IV);
    chk("blk_ready0", 1024'(msg_ready), 1024'(0));
    for (int i = 1; i < L; i++) begin
      tick();
      chk("blk_ready_run", 1024'(msg_ready), 1024'(0));
      chk("blk_dvalid_run", 1024'(digest_valid), 1024'(0));
    end
    tick();
    chk("blk_dvalid", 1024'(digest_valid), 1024'(1));
    chk("blk_digest", 1024'(digest_data), 1024'(ones));
    chk("blk_h_top",  1024'(dut.h_reg[1023:1008]), 1024'(16'hFEFF));

    // Backpressure with stray msg_valid pulses.
    digest_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      msg_valid = 1'($urandom);
      msg_data  = rnd512();
      tick();
      chk("bp_dvalid", 1024'(digest_valid), 1024'(1));
      chk("bp_digest", 1024'(digest_data), 1024'(ones));
      chk("bp_ready",  1024'(msg_ready), 1024'(0));
    end
    msg_valid = 1'b0;
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    chk("take_dvalid", 1024'(digest_valid), 1024'(0));
    chk("take_h",      dut.h_reg, IV);
    tick();
    chk("take_ready", 1024'(msg_ready), 1024'(1));

    // Two blocks: 512'h1 then 0 (last).
    msg_valid = 1'b1; msg_data = 512'h1; msg_last = 1'b0;
    tick();
    msg_valid = 1'b0;
    for (int i = 1; i < L; i++) begin
      tick();
      chk("two_ready_run", 1024'(msg_ready), 1024'(0));
    end
    tick();
    chk("two_ready_again", 1024'(msg_ready), 1024'(1));
    chk("two_h1", dut.h_reg, h1);
    msg_valid = 1'b1; msg_data = '0; msg_last = 1'b1;
    tick();
    msg_valid = 1'b0;
    chk("two_f8_in_lo",  1024'(f8_state_in[255:0]), 1024'({{255{1'b1}}, 1'b0}));
    chk("two_f8_in_top", 1024'(f8_state_in[1023:1008]), 1024'(16'hFEFF));
    for (int i = 0; i < L; i++) tick();
    chk("two_digest", 1024'(digest_data), 1024'(256'h1));
    digest_ready = 1'b1;
    tick();
    digest_ready = 1'b0;
    tick();

    // Reset two cycles into RUN.
    msg_valid = 1'b1; msg_data = rnd512(); msg_last = 1'b1;
    tick();
    msg_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    chk("rrun_h", dut.h_reg, IV);
    chk("rrun_ready", 1024'(msg_ready), 1024'(0));
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("rrun_no_dvalid", 1024'(digest_valid), 1024'(0));
      chk("rrun_h_hold",    dut.h_reg, IV);
    end

    // Random traffic; the model checks every cycle.
    for (int i = 0; i < 2000; i++) begin
      rst          = ($urandom_range(0, 149) == 0);
      msg_valid    = 1'($urandom);
      msg_last     = ($urandom_range(0, 2) == 0);
      msg_data     = rnd512();
      digest_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    rst = 1'b0;
    msg_valid = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
